// File: rtl/traffic_light_controller.sv
// Four-approach signal sequencer: one Moore FSM with a WL-bit phase timer steps
// EW, WN_ES, NS, NE_SW phases; Car decides whether each turn phase is served.
module traffic_light_controller #(
    parameter int unsigned WL = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic Car,
    output logic Green_WN_ES,
    output logic Yellow_WN_ES,
    output logic Red_WN_ES,
    output logic Green_NE_SW,
    output logic Yellow_NE_SW,
    output logic Red_NE_SW,
    output logic Green_EW,
    output logic Yellow_EW,
    output logic Red_EW,
    output logic Green_NS,
    output logic Yellow_NS,
    output logic Red_NS
);

    localparam logic [WL-1:0] GreenLast  = {WL{1'b1}};
    localparam logic [WL-1:0] YellowLast = WL'((2 ** (WL - 2)) - 1);

    typedef enum logic [3:0] {
        StAllRed = 4'd0,
        StEwG    = 4'd1,
        StEwY    = 4'd2,
        StWnesG  = 4'd3,
        StWnesY  = 4'd4,
        StNsG    = 4'd5,
        StNsY    = 4'd6,
        StNeswG  = 4'd7,
        StNeswY  = 4'd8
    } state_e;

    state_e          state_q;
    logic [WL-1:0]   timer_q;
    logic            green_done;
    logic            yellow_done;

    assign green_done  = (timer_q == GreenLast);
    assign yellow_done = (timer_q == YellowLast);

    // Every branch that changes state also clears the timer; otherwise it counts up.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StAllRed;
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 1'b1;
            case (state_q)
                StAllRed: begin
                    state_q <= StEwG;
                    timer_q <= '0;
                end
                StEwG: if (green_done) begin
                    state_q <= StEwY;
                    timer_q <= '0;
                end
                StEwY: if (yellow_done) begin
                    state_q <= Car ? StWnesG : StNsG;
                    timer_q <= '0;
                end
                StWnesG: if (green_done) begin
                    state_q <= StWnesY;
                    timer_q <= '0;
                end
                StWnesY: if (yellow_done) begin
                    state_q <= StNsG;
                    timer_q <= '0;
                end
                StNsG: if (green_done) begin
                    state_q <= StNsY;
                    timer_q <= '0;
                end
                StNsY: if (yellow_done) begin
                    state_q <= Car ? StNeswG : StEwG;
                    timer_q <= '0;
                end
                StNeswG: if (green_done) begin
                    state_q <= StNeswY;
                    timer_q <= '0;
                end
                StNeswY: if (yellow_done) begin
                    state_q <= StEwG;
                    timer_q <= '0;
                end
                default: begin
                    state_q <= StAllRed;
                    timer_q <= '0;
                end
            endcase
        end
    end

    // Movement index: 0 EW, 1 WN_ES, 2 NS, 3 NE_SW. Red is derived so exactly one lamp is lit.
    logic [3:0] grn;
    logic [3:0] yel;

    always_comb begin
        grn = '0;
        yel = '0;
        case (state_q)
            StEwG:   grn[0] = 1'b1;
            StEwY:   yel[0] = 1'b1;
            StWnesG: grn[1] = 1'b1;
            StWnesY: yel[1] = 1'b1;
            StNsG:   grn[2] = 1'b1;
            StNsY:   yel[2] = 1'b1;
            StNeswG: grn[3] = 1'b1;
            StNeswY: yel[3] = 1'b1;
            default: ;
        endcase
    end

    assign Green_EW     = grn[0];
    assign Yellow_EW    = yel[0];
    assign Red_EW       = ~(grn[0] | yel[0]);
    assign Green_WN_ES  = grn[1];
    assign Yellow_WN_ES = yel[1];
    assign Red_WN_ES    = ~(grn[1] | yel[1]);
    assign Green_NS     = grn[2];
    assign Yellow_NS    = yel[2];
    assign Red_NS       = ~(grn[2] | yel[2]);
    assign Green_NE_SW  = grn[3];
    assign Yellow_NE_SW = yel[3];
    assign Red_NE_SW    = ~(grn[3] | yel[3]);

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: phase-schedule reference model driven by
// Car stimulus, per-scenario tasks, plus a per-cycle lamp safety monitor.
module tb_traffic_light_controller;

    localparam int WL    = 4;
    localparam int GREEN = 1 << WL;
    localparam int YEL   = 1 << (WL - 2);
    localparam int PH    = GREEN + YEL;
    localparam logic [11:0] ALL_RED_V  = 12'b001_001_001_001;
    localparam logic [11:0] EW_GREEN_V = 12'b100_001_001_001;

    logic CLK = 1'b0;
    logic RST;
    logic Car;
    logic Green_WN_ES, Yellow_WN_ES, Red_WN_ES;
    logic Green_NE_SW, Yellow_NE_SW, Red_NE_SW;
    logic Green_EW, Yellow_EW, Red_EW;
    logic Green_NS, Yellow_NS, Red_NS;
    logic [11:0] obs;

    int checks   = 0;
    int failures = 0;

    // Reference model: movement m (0 EW, 1 WN_ES, 2 NS, 3 NE_SW), cycles elapsed in its phase.
    bit allred = 1'b1;
    int m      = 0;
    int el     = 0;

    traffic_light_controller #(.WL(WL)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Car          (Car),
        .Green_WN_ES  (Green_WN_ES),
        .Yellow_WN_ES (Yellow_WN_ES),
        .Red_WN_ES    (Red_WN_ES),
        .Green_NE_SW  (Green_NE_SW),
        .Yellow_NE_SW (Yellow_NE_SW),
        .Red_NE_SW    (Red_NE_SW),
        .Green_EW     (Green_EW),
        .Yellow_EW    (Yellow_EW),
        .Red_EW       (Red_EW),
        .Green_NS     (Green_NS),
        .Yellow_NS    (Yellow_NS),
        .Red_NS       (Red_NS)
    );

    always #5 CLK = ~CLK;

    assign obs = {Green_EW, Yellow_EW, Red_EW, Green_WN_ES, Yellow_WN_ES, Red_WN_ES,
                  Green_NS, Yellow_NS, Red_NS, Green_NE_SW, Yellow_NE_SW, Red_NE_SW};

    function automatic logic [11:0] exp_lamps();
        logic [11:0] v;
        v = ALL_RED_V;
        if (!allred) v[(3 - m) * 3 +: 3] = (el < GREEN) ? 3'b100 : 3'b010;
        return v;
    endfunction

    // Drive Car for one cycle, advance the model across the rising edge, settle past it.
    task automatic step(input logic car);
        Car = car;
        @(posedge CLK);
        if (!RST) begin
            allred = 1'b1;
        end else if (allred) begin
            allred = 1'b0;
            m      = 0;
            el     = 0;
        end else if (el == PH - 1) begin
            if (m % 2 == 0) m = car ? m + 1 : m + 2;
            else            m = m + 1;
            m  = m % 4;
            el = 0;
        end else begin
            el++;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST    = 1'b0;
        allred = 1'b1;
        @(negedge CLK);
        RST    = 1'b1;
    endtask

    // Safety: one lamp per movement and at most one movement non-red, every cycle.
    always @(negedge CLK) begin
        int nonred;
        nonred = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ($countones(obs[i*3 +: 3]) != 1) begin
                failures++;
                $display("FAIL safety_onehot mov=%0d lamps=%b required exactly one lit", 3 - i,
                         obs[i*3 +: 3]);
            end
            if (obs[i*3] == 1'b0) nonred++;
        end
        checks++;
        if (nonred > 1) begin
            failures++;
            $display("FAIL safety_conflict lamps=%b non_red=%0d required <=1", obs, nonred);
        end
    end

    task automatic test_reset();
        RST = 1'b0;
        Car = 1'b0;
        allred = 1'b1;
        #3;
        checks++;
        if (obs !== ALL_RED_V) begin
            failures++;
            $display("FAIL reset_async lamps=%b required %b", obs, ALL_RED_V);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1);
            checks++;
            if (obs !== ALL_RED_V) begin
                failures++;
                $display("FAIL reset_hold lamps=%b required %b", obs, ALL_RED_V);
            end
        end
        RST = 1'b1;
        step(1'b0);
        checks++;
        if (obs !== EW_GREEN_V || obs !== exp_lamps()) begin
            failures++;
            $display("FAIL reset_release lamps=%b required %b", obs, EW_GREEN_V);
        end
    endtask

    task automatic test_car_high();
        int wnes_g, ew_y;
        wnes_g = 0;
        ew_y   = 0;
        do_reset();
        for (int k = 1; k <= 81; k++) begin
            step(1'b1);
            checks++;
            if (obs !== exp_lamps()) begin
                failures++;
                $display("FAIL car_high cyc=%0d lamps=%b required %b", k, obs, exp_lamps());
            end
            if (Green_WN_ES) wnes_g++;
            if (Yellow_EW) ew_y++;
            if (k == 80) begin
                checks++;
                if (Yellow_NE_SW !== 1'b1) begin
                    failures++;
                    $display("FAIL car_high_nesw_y cyc=80 Yellow_NE_SW=%b required 1", Yellow_NE_SW);
                end
            end
        end
        checks++;
        if (Green_EW !== 1'b1) begin
            failures++;
            $display("FAIL car_high_wrap cyc=81 Green_EW=%b required 1", Green_EW);
        end
        checks++;
        if (wnes_g != GREEN || ew_y != YEL) begin
            failures++;
            $display("FAIL car_high_len wnes_green=%0d ew_yellow=%0d required %0d %0d",
                     wnes_g, ew_y, GREEN, YEL);
        end
    endtask

    task automatic test_car_low();
        int ew_g, turns;
        ew_g  = 0;
        turns = 0;
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            step(1'b0);
            checks++;
            if (obs !== exp_lamps()) begin
                failures++;
                $display("FAIL car_low cyc=%0d lamps=%b required %b", k, obs, exp_lamps());
            end
            if (Green_EW) ew_g++;
            if (!Red_WN_ES || !Red_NE_SW) turns++;
            if (k == 21 || k == 41) begin
                checks++;
                if ((k == 21 && Green_NS !== 1'b1) || (k == 41 && Green_EW !== 1'b1)) begin
                    failures++;
                    $display("FAIL car_low_alt cyc=%0d lamps=%b required straight green", k, obs);
                end
            end
        end
        checks++;
        if (ew_g != 2 * GREEN || turns != 0) begin
            failures++;
            $display("FAIL car_low_count ew_green=%0d turn_cycles=%0d required %0d 0",
                     ew_g, turns, 2 * GREEN);
        end
    endtask

    task automatic test_car_pulse();
        bit wnes_seen, nesw_seen;
        logic c;
        wnes_seen = 0;
        nesw_seen = 0;
        do_reset();
        for (int k = 1; k <= 81; k++) begin
            c = (!allred && m == 0 && el == PH - 1);
            step(c);
            checks++;
            if (obs !== exp_lamps()) begin
                failures++;
                $display("FAIL pulse_ewy cyc=%0d lamps=%b required %b", k, obs, exp_lamps());
            end
            if (!Red_WN_ES) wnes_seen = 1;
            if (!Red_NE_SW) nesw_seen = 1;
        end
        checks++;
        if (wnes_seen != 1 || nesw_seen != 0) begin
            failures++;
            $display("FAIL pulse_ewy_turns wnes=%0d nesw=%0d required 1 0", wnes_seen, nesw_seen);
        end
        wnes_seen = 0;
        nesw_seen = 0;
        do_reset();
        for (int k = 1; k <= 81; k++) begin
            c = (!allred && m == 0 && el < GREEN);
            step(c);
            checks++;
            if (obs !== exp_lamps()) begin
                failures++;
                $display("FAIL pulse_ewg cyc=%0d lamps=%b required %b", k, obs, exp_lamps());
            end
            if (!Red_WN_ES) wnes_seen = 1;
            if (!Red_NE_SW) nesw_seen = 1;
        end
        checks++;
        if (wnes_seen != 0 || nesw_seen != 0) begin
            failures++;
            $display("FAIL pulse_ewg_turns wnes=%0d nesw=%0d required 0 0", wnes_seen, nesw_seen);
        end
    endtask

    task automatic test_midphase_reset();
        bit found;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step(1'($urandom));
            if (!allred && m == 2 && el == 5) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midreset_reach ns_green_seen=0 required 1");
        end
        #3;
        RST = 1'b0;
        allred = 1'b1;
        #1;
        checks++;
        if (obs !== ALL_RED_V) begin
            failures++;
            $display("FAIL midreset_async lamps=%b required %b", obs, ALL_RED_V);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            checks++;
            if (obs !== ALL_RED_V) begin
                failures++;
                $display("FAIL midreset_hold lamps=%b required %b", obs, ALL_RED_V);
            end
        end
        RST = 1'b1;
        step(1'b0);
        checks++;
        if (obs !== EW_GREEN_V || obs !== exp_lamps()) begin
            failures++;
            $display("FAIL midreset_restart lamps=%b required %b", obs, EW_GREEN_V);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(1, 0)));
            checks++;
            if (obs !== exp_lamps()) begin
                failures++;
                $display("FAIL random cyc=%0d lamps=%b required %b", k, obs, exp_lamps());
            end
        end
    endtask

    initial begin
        test_reset();
        test_car_high();
        test_car_low();
        test_car_pulse();
        test_midphase_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
